mb_neighbour_fetcher: RTL and testbench

- Parametrised successor to the fixed 16x16 luma extractor in IntraPred.
- Sequentially fetches one macroblock and its neighbours from an external frame memory: body, top row, left column, top-left and optional top-right.
- Reads go through a fixed-latency read port, one pixel per cycle.
- Handles luma or chroma block geometry via parameters; frame-edge neighbours are replaced by the mid-grey default.

---
 rtl/mb_fetch_pkg.sv | 21 ++
 rtl/mb_addr_gen.sv | 46 ++++
 rtl/mb_neighbour_fetcher.sv | 233 +++++++++++++++++++++++
 tb/tb_mb_neighbour_fetcher.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mb_fetch_pkg.sv
// Shared FSM state codes, region tags and pixel default for the macroblock neighbour fetcher.
package mb_fetch_pkg;

    // Codes are ordered in fetch sequence order; the next-region search relies on it.
    localparam logic [3:0] StIdle      = 4'd0;
    localparam logic [3:0] StSetup     = 4'd1;
    localparam logic [3:0] StFetchTl   = 4'd2;
    localparam logic [3:0] StFetchTop  = 4'd3;
    localparam logic [3:0] StFetchTr   = 4'd4;
    localparam logic [3:0] StFetchLeft = 4'd5;
    localparam logic [3:0] StFetchMb   = 4'd6;
    localparam logic [3:0] StDrain     = 4'd7;
    localparam logic [3:0] StFinish    = 4'd8;

    typedef enum logic [2:0] {RegTl, RegTop, RegTr, RegLeft, RegMb} region_e;

    function automatic logic [31:0] default_pix(input int unsigned pix_w);
        return 32'd1 << (pix_w - 1);
    endfunction

endpackage

// File: rtl/mb_addr_gen.sv
// Maps (block origin, region, index) to a frame memory address and the return-steering tag.
module mb_addr_gen
    import mb_fetch_pkg::*;
#(
    parameter int unsigned FRAME_W = 1280,
    parameter int unsigned MB_W    = 16,
    parameter int unsigned ADDR_W  = 20,
    parameter int unsigned IDX_W   = 8
) (
    input  logic [ADDR_W-1:0] px,
    input  logic [ADDR_W-1:0] py,
    input  region_e           region,
    input  logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] addr,
    output region_e           tag_region,
    output logic [IDX_W-1:0]  tag_idx
);

    localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] MBW_A = ADDR_W'(MB_W);
    localparam logic [ADDR_W-1:0] FW_A  = ADDR_W'(FRAME_W);

    logic [ADDR_W-1:0] idx_a;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;

    assign idx_a = ADDR_W'(idx);

    always_comb begin
        row = py;
        col = px;
        unique case (region)
            RegTl:   begin row = py - ONE;           col = px - ONE;               end
            RegTop:  begin row = py - ONE;           col = px + idx_a;             end
            RegTr:   begin row = py - ONE;           col = px + MBW_A + idx_a;     end
            RegLeft: begin row = py + idx_a;         col = px - ONE;               end
            RegMb:   begin row = py + idx_a / MBW_A; col = px + idx_a % MBW_A;     end
            default: ;
        endcase
    end

    assign addr       = row * FW_A + col;
    assign tag_region = region;
    assign tag_idx    = idx;

endmodule

// File: rtl/mb_neighbour_fetcher.sv
// Fetches one macroblock plus top/left/top-left neighbours from frame memory, one pixel per cycle.
// Define TOPRIGHT_EN to add the top-right neighbour row (port topright_flat).
module mb_neighbour_fetcher
    import mb_fetch_pkg::*;
#(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned FRAME_W = 1280,
    parameter int unsigned FRAME_H = 720,
    parameter int unsigned MB_W    = 16,
    parameter int unsigned MB_H    = 16,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned MBN_W   = 13,
    parameter int unsigned ADDR_W  = $clog2(FRAME_W * FRAME_H)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [MBN_W-1:0]            mbnumber,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic                        mem_rd_en,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [PIX_W-1:0]            mem_rdata,
    output logic [MB_W*MB_H*PIX_W-1:0]  mb_flat,
    output logic [MB_W*PIX_W-1:0]       top_flat,
`ifdef TOPRIGHT_EN
    output logic [MB_W*PIX_W-1:0]       topright_flat,
`endif
    output logic [MB_H*PIX_W-1:0]       left_flat,
    output logic [PIX_W-1:0]            topleft,
    output logic                        out_valid
);

    localparam int unsigned MBS_X   = FRAME_W / MB_W;
    localparam int unsigned MBS_Y   = FRAME_H / MB_H;
    localparam int unsigned IDX_W   = $clog2(MB_W * MB_H);
    localparam int unsigned TOP_IW  = $clog2(MB_W);
    localparam int unsigned LEFT_IW = $clog2(MB_H);
    localparam int unsigned LAT_W   = $clog2(MEM_LAT + 1);
    localparam logic [PIX_W-1:0] DEF = PIX_W'(default_pix(PIX_W));

    logic [3:0]        state_q, state_d;
    logic [MBN_W-1:0]  mbn_q;
    logic [IDX_W-1:0]  idx_q, last_idx;
    logic [LAT_W-1:0]  drain_q;
    logic [ADDR_W-1:0] px_q, py_q, px_c, py_c, gen_addr;
    logic              err_q, out_valid_q;
    logic [31:0]       mbn32, mb_x, mb_y;
    logic              in_range, has_top, has_left, has_tl, has_tr, rd_en;
    region_e           cur_reg, gen_reg;
    logic [IDX_W-1:0]  gen_idx;

    logic [MB_W*MB_H-1:0][PIX_W-1:0] mb_q;
    logic [MB_W-1:0][PIX_W-1:0]      top_q;
    logic [MB_H-1:0][PIX_W-1:0]      left_q;
    logic [PIX_W-1:0]                tl_q;
`ifdef TOPRIGHT_EN
    logic [MB_W-1:0][PIX_W-1:0]      tr_q;
    logic                            tr_rep_q;
`endif

    logic             pipe_vld_q [MEM_LAT];
    region_e          pipe_reg_q [MEM_LAT];
    logic [IDX_W-1:0] pipe_idx_q [MEM_LAT];

    assign mbn32    = 32'(mbn_q);
    assign mb_x     = mbn32 % MBS_X;
    assign mb_y     = mbn32 / MBS_X;
    assign in_range = mbn32 < MBS_X * MBS_Y;
    assign has_top  = mb_y != 32'd0;
    assign has_left = mb_x != 32'd0;
    assign has_tl   = has_top && has_left;
    assign px_c     = ADDR_W'(mb_x * MB_W);
    assign py_c     = ADDR_W'(mb_y * MB_H);
`ifdef TOPRIGHT_EN
    assign has_tr   = has_top && (mb_x < MBS_X - 1);
`else
    assign has_tr   = 1'b0;
`endif

    // First available region strictly after st; unavailable regions cost no cycles.
    function automatic logic [3:0] next_after(input logic [3:0] st, input logic tl,
                                              input logic top, input logic tr, input logic lf);
        if (st < StFetchTl && tl) return StFetchTl;
        if (st < StFetchTop && top) return StFetchTop;
        if (st < StFetchTr && tr) return StFetchTr;
        if (st < StFetchLeft && lf) return StFetchLeft;
        if (st < StFetchMb) return StFetchMb;
        return StDrain;
    endfunction

    assign rd_en = (state_q >= StFetchTl) && (state_q <= StFetchMb);

    always_comb begin
        cur_reg  = RegMb;
        last_idx = IDX_W'(MB_W * MB_H - 1);
        case (state_q)
            StFetchTl:   begin cur_reg = RegTl;   last_idx = '0;                end
            StFetchTop:  begin cur_reg = RegTop;  last_idx = IDX_W'(MB_W - 1);  end
            StFetchTr:   begin cur_reg = RegTr;   last_idx = IDX_W'(MB_W - 1);  end
            StFetchLeft: begin cur_reg = RegLeft; last_idx = IDX_W'(MB_H - 1);  end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StSetup;
            StSetup: state_d = in_range ? next_after(StSetup, has_tl, has_top, has_tr, has_left)
                                        : StFinish;
            StFetchTl, StFetchTop, StFetchTr, StFetchLeft, StFetchMb:
                if (idx_q == last_idx)
                    state_d = next_after(state_q, has_tl, has_top, has_tr, has_left);
            StDrain: if (drain_q == LAT_W'(MEM_LAT - 1)) state_d = StFinish;
            default: state_d = StIdle;
        endcase
    end

    mb_addr_gen #(
        .FRAME_W (FRAME_W),
        .MB_W    (MB_W),
        .ADDR_W  (ADDR_W),
        .IDX_W   (IDX_W)
    ) u_addr_gen (
        .px         (px_q),
        .py         (py_q),
        .region     (cur_reg),
        .idx        (idx_q),
        .addr       (gen_addr),
        .tag_region (gen_reg),
        .tag_idx    (gen_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            mbn_q       <= '0;
            idx_q       <= '0;
            drain_q     <= '0;
            px_q        <= '0;
            py_q        <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            mb_q        <= '0;
            top_q       <= '0;
            left_q      <= '0;
            tl_q        <= '0;
`ifdef TOPRIGHT_EN
            tr_q        <= '0;
            tr_rep_q    <= 1'b0;
`endif
            for (int k = 0; k < MEM_LAT; k++) begin
                pipe_vld_q[k] <= 1'b0;
                pipe_reg_q[k] <= RegTl;
                pipe_idx_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= (rd_en && state_d == state_q) ? idx_q + 1'b1 : '0;
            drain_q <= (state_q == StDrain) ? drain_q + 1'b1 : '0;

            if (state_q == StIdle && start) begin
                mbn_q       <= mbnumber;
                out_valid_q <= 1'b0;
                err_q       <= 1'b0;
            end

            if (state_q == StSetup) begin
                px_q <= px_c;
                py_q <= py_c;
                if (!in_range) begin
                    err_q <= 1'b1;
                end else begin
                    if (!has_tl)   tl_q   <= DEF;
                    if (!has_top)  top_q  <= {MB_W{DEF}};
                    if (!has_left) left_q <= {MB_H{DEF}};
`ifdef TOPRIGHT_EN
                    tr_rep_q <= has_top && !has_tr;
                    if (!has_top) tr_q <= {MB_W{DEF}};
`endif
                end
            end

            if (state_q == StDrain && state_d == StFinish) out_valid_q <= 1'b1;

            pipe_vld_q[0] <= rd_en;
            pipe_reg_q[0] <= gen_reg;
            pipe_idx_q[0] <= gen_idx;
            for (int k = MEM_LAT - 1; k > 0; k--) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_reg_q[k] <= pipe_reg_q[k-1];
                pipe_idx_q[k] <= pipe_idx_q[k-1];
            end

            if (pipe_vld_q[MEM_LAT-1]) begin
                unique case (pipe_reg_q[MEM_LAT-1])
                    RegTl:   tl_q <= mem_rdata;
                    RegTop: begin
                        top_q[TOP_IW'(pipe_idx_q[MEM_LAT-1])] <= mem_rdata;
`ifdef TOPRIGHT_EN
                        // At the right frame edge the top-right row replicates the last top pixel.
                        if (tr_rep_q && pipe_idx_q[MEM_LAT-1] == IDX_W'(MB_W - 1))
                            tr_q <= {MB_W{mem_rdata}};
`endif
                    end
`ifdef TOPRIGHT_EN
                    RegTr:   tr_q[TOP_IW'(pipe_idx_q[MEM_LAT-1])] <= mem_rdata;
`endif
                    RegLeft: left_q[LEFT_IW'(pipe_idx_q[MEM_LAT-1])] <= mem_rdata;
                    RegMb:   mb_q[IDX_W'(pipe_idx_q[MEM_LAT-1])] <= mem_rdata;
                    default: ;
                endcase
            end
        end
    end

    assign busy      = (state_q != StIdle) && (state_q != StFinish);
    assign done      = state_q == StFinish;
    assign err       = done && err_q;
    assign mem_rd_en = rd_en;
    assign mem_addr  = rd_en ? gen_addr : '0;
    assign mb_flat   = mb_q;
    assign top_flat  = top_q;
    assign left_flat = left_q;
    assign topleft   = tl_q;
    assign out_valid = out_valid_q;
`ifdef TOPRIGHT_EN
    assign topright_flat = tr_q;
`endif

endmodule

// File: tb/tb_mb_neighbour_fetcher.sv
// Directed bench for mb_neighbour_fetcher on a 64x32 frame with 16x16 blocks and latency 1.
module tb_mb_neighbour_fetcher;

    localparam int PW = 8;
    localparam int FW = 64;
    localparam int FH = 32;
    localparam int MW = 16;
    localparam int MH = 16;
    localparam int AW = 11;

`ifdef TOPRIGHT_EN
    localparam int N5 = 305;
`else
    localparam int N5 = 289;
`endif

    logic               clk;
    logic               reset;
    logic               start;
    logic [12:0]        mbnumber;
    logic               busy, done, err, mem_rd_en, out_valid;
    logic [AW-1:0]      mem_addr;
    logic [PW-1:0]      mem_rdata;
    logic [MW*MH*PW-1:0] mb_flat;
    logic [MW*PW-1:0]   top_flat;
    logic [MH*PW-1:0]   left_flat;
    logic [PW-1:0]      topleft;
`ifdef TOPRIGHT_EN
    logic [MW*PW-1:0]   topright_flat;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [MW*MH*PW-1:0] exp_mb;
    logic [MW*PW-1:0]    exp_top;
    logic [MH*PW-1:0]    exp_left;

    mb_neighbour_fetcher #(
        .PIX_W   (PW),
        .FRAME_W (FW),
        .FRAME_H (FH),
        .MB_W    (MW),
        .MB_H    (MH),
        .MEM_LAT (1),
        .MBN_W   (13),
        .ADDR_W  (AW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .mbnumber      (mbnumber),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mem_rd_en     (mem_rd_en),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .mb_flat       (mb_flat),
        .top_flat      (top_flat),
`ifdef TOPRIGHT_EN
        .topright_flat (topright_flat),
`endif
        .left_flat     (left_flat),
        .topleft       (topleft),
        .out_valid     (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'((x + 3 * y) % 256);
    endfunction

    always @(posedge clk)
        if (mem_rd_en) mem_rdata <= pix(int'(mem_addr) % FW, int'(mem_addr) / FW);

    function automatic logic [MW*MH*PW-1:0] body_of(input int px, input int py);
        logic [MW*MH*PW-1:0] v;
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++)
                v[(r*MW+c)*PW +: PW] = pix(px + c, py + r);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_body(input string tag, input logic [MW*MH*PW-1:0] exp);
        for (int k = 0; k < 8; k++)
            chk($sformatf("%s_chunk%0d", tag, k), mb_flat[k*256 +: 256], exp[k*256 +: 256]);
    endtask

    // Issues one fetch and checks completion cycle, read count and err; optional stray start at T50.
    task automatic fetch(input logic [12:0] mbn, input int exp_done, input int exp_reads,
                         input logic exp_err, input bit stray_start, input string tag);
        int cyc;
        int reads;
        @(negedge clk);
        mbnumber = mbn;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        reads = 0;
        chk({tag, "_busy_t1"}, 256'(busy), 256'(1));
        chk({tag, "_outvalid_t1"}, 256'(out_valid), 256'(0));
        while (cyc < 600) begin
            if (mem_rd_en) reads++;
            if (done) break;
            if (stray_start && cyc == 50) begin
                start    = 1'b1;
                mbnumber = 13'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, 256'(cyc), 256'(exp_done));
        chk({tag, "_reads"}, 256'(reads), 256'(exp_reads));
        chk({tag, "_err"}, 256'(err), 256'(exp_err));
        chk({tag, "_outvalid"}, 256'(out_valid), 256'(!exp_err));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 256'({done, busy}), 256'(0));
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        mbnumber = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 256'({busy, done, err, mem_rd_en, out_valid}), 256'(0));
        chk("reset_tl_top", 256'({topleft, top_flat}), 256'(0));
        chk("reset_left", 256'(left_flat), 256'(0));
        chk("reset_mb0", mb_flat[255:0], 256'(0));
        reset = 1'b1;

        // Corner block: every neighbour takes the default.
        fetch(13'd0, 259, 256, 1'b0, 1'b0, "mb0");
        chk("mb0_topleft", 256'(topleft), 256'(128));
        chk("mb0_top", 256'(top_flat), 256'({16{8'd128}}));
        chk("mb0_left", 256'(left_flat), 256'({16{8'd128}}));
        chk("mb0_first", 256'(mb_flat[7:0]), 256'(0));
        chk("mb0_last", 256'(mb_flat[255*8 +: 8]), 256'(60));
        chk_body("mb0_body", body_of(0, 0));

        // Interior block at (16,16).
        fetch(13'd5, N5 + 3, N5, 1'b0, 1'b0, "mb5");
        for (int j = 0; j < 16; j++) exp_top[j*8 +: 8] = 8'(61 + j);
        for (int i = 0; i < 16; i++) exp_left[i*8 +: 8] = 8'(63 + 3 * i);
        chk("mb5_topleft", 256'(topleft), 256'(60));
        chk("mb5_top", 256'(top_flat), 256'(exp_top));
        chk("mb5_left", 256'(left_flat), 256'(exp_left));
        chk("mb5_first", 256'(mb_flat[7:0]), 256'(64));
        chk_body("mb5_body", body_of(16, 16));

        // Top-edge block at (48,0).
        fetch(13'd3, 275, 272, 1'b0, 1'b0, "mb3");
        for (int i = 0; i < 16; i++) exp_left[i*8 +: 8] = 8'(47 + 3 * i);
        exp_mb = body_of(48, 0);
        chk("mb3_topleft", 256'(topleft), 256'(128));
        chk("mb3_top", 256'(top_flat), 256'({16{8'd128}}));
        chk("mb3_left", 256'(left_flat), 256'(exp_left));
        chk_body("mb3_body", exp_mb);

        // Out-of-range index: no reads, data outputs keep the mb3 result.
        fetch(13'd8, 2, 0, 1'b1, 1'b0, "mb8");
        chk("mb8_topleft", 256'(topleft), 256'(128));
        chk("mb8_top", 256'(top_flat), 256'({16{8'd128}}));
        chk("mb8_left", 256'(left_flat), 256'(exp_left));
        chk_body("mb8_body", exp_mb);

        // Reset in the middle of a fetch.
        @(negedge clk);
        mbnumber = 13'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_ctrl", 256'({busy, done, err, mem_rd_en, out_valid}), 256'(0));
        chk("rst_addr", 256'(mem_addr), 256'(0));
        chk("rst_tl_top", 256'({topleft, top_flat}), 256'(0));
        chk("rst_left", 256'(left_flat), 256'(0));
        chk("rst_mb0", mb_flat[255:0], 256'(0));
        @(negedge clk);
        chk("rst_flushed", mb_flat[255:0], 256'(0));
        chk("rst_idle", 256'({busy, mem_rd_en}), 256'(0));

        // Refetch with a stray start mid-fetch, which must not restart or queue a fetch.
        fetch(13'd5, N5 + 3, N5, 1'b0, 1'b1, "mb5b");
        for (int j = 0; j < 16; j++) exp_top[j*8 +: 8] = 8'(61 + j);
        chk("mb5b_top", 256'(top_flat), 256'(exp_top));
        chk_body("mb5b_body", body_of(16, 16));
        repeat (4) @(negedge clk);
        chk("mb5b_no_queue", 256'({busy, mem_rd_en, done}), 256'(0));

`ifdef TOPRIGHT_EN
        fetch(13'd4, 291, 288, 1'b0, 1'b0, "tr4");
        for (int j = 0; j < 16; j++) exp_top[j*8 +: 8] = 8'(61 + j);
        chk("tr4_topright", 256'(topright_flat), 256'(exp_top));
        fetch(13'd7, 292, 289, 1'b0, 1'b0, "tr7");
        chk("tr7_topright", 256'(topright_flat), 256'({16{8'd108}}));
        fetch(13'd1, 275, 272, 1'b0, 1'b0, "tr1");
        chk("tr1_topright", 256'(topright_flat), 256'({16{8'd128}}));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
